// File: rtl/cordic_hyp_ctrl.sv
// Iterative hyperbolic CORDIC: one shift-add step per clock, rotation or vectoring mode.
// The atanh LUT is external and combinational; lut_idx follows the iteration counter.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | one CORDIC step per cycle, lut_idx = iteration index
// DONE  | result held on x/y/z_out until out_ready
module cordic_hyp_ctrl #(
  parameter int W        = 26,
  parameter int ITER_MAX = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  output logic [5:0]   lut_idx,
  input  logic [W-1:0] lut_atanh,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic signed [W-1:0] x_r, y_r, z_r;
  logic signed [W-1:0] x_sh, y_sh, x_nx, y_nx, z_nx;
  logic [5:0] iter;
  logic       rep, mode_r;
  logic       rep_now, last_step, d_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    lut_idx   = 6'd0;
    // Indices 4 and 13 run twice; the first pass sets rep and holds the index.
    rep_now   = ((iter == 6'd4) || (iter == 6'd13)) && !rep;
    last_step = (iter == 6'(ITER_MAX)) && !rep_now;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        lut_idx = iter;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    d_pos = mode_r ? y_r[W-1] : ~z_r[W-1];
    x_sh  = x_r >>> iter;
    y_sh  = y_r >>> iter;
    if (d_pos) begin
      x_nx = x_r + y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - $signed(lut_atanh);
    end else begin
      x_nx = x_r - y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + $signed(lut_atanh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      iter   <= 6'd0;
      rep    <= 1'b0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= x_in;
            y_r    <= y_in;
            z_r    <= z_in;
            mode_r <= mode;
            iter   <= 6'd1;
            rep    <= 1'b0;
          end
        end
        RUN: begin
          x_r <= x_nx;
          y_r <= y_nx;
          z_r <= z_nx;
          if (rep_now) begin
            rep <= 1'b1;
          end else begin
            rep  <= 1'b0;
            iter <= iter + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_out = x_r;
  assign y_out = y_r;
  assign z_out = z_r;

endmodule
